// File: rtl/reaction_timer_if.sv
// Signal bundle between the debouncer/display stages and the reaction timer core.
// result_valid is a one-cycle pulse with no back-pressure; the result fields stay stable until the next start.
interface reaction_timer_if;
  logic        start_sustain;
  logic        react_sustain;
  logic        led_go;
  logic [13:0] reaction_ms;
  logic        result_valid;
  logic        foul;
  logic        timeout;
  logic        busy;
  logic [2:0]  state_dbg;

  modport master (
    output start_sustain,
    output react_sustain,
    input  led_go,
    input  reaction_ms,
    input  result_valid,
    input  foul,
    input  timeout,
    input  busy,
    input  state_dbg
  );

  modport slave (
    input  start_sustain,
    input  react_sustain,
    output led_go,
    output reaction_ms,
    output result_valid,
    output foul,
    output timeout,
    output busy,
    output state_dbg
  );
endinterface

// File: rtl/reaction_timer.sv
// Reaction timer core: random pre-GO delay, millisecond reaction count, foul/timeout detection.
// Button inputs are already debounced levels; only their rising edges matter.
module reaction_timer #(
  parameter int TICKS_PER_MS   = 100000,
  parameter int DELAY_MIN_MS   = 1000,
  parameter int FIXED_DELAY_MS = 0,
  parameter int MAX_MS         = 9999
) (
  input  logic             clock,
  input  logic             reset,
  reaction_timer_if.slave  rt
);

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICKS_PER_MS - 1);
  localparam logic [13:0]   MAX_V     = 14'(MAX_MS);
  localparam logic [15:0]   FIXED_V   = 16'(FIXED_DELAY_MS);
  localparam logic [15:0]   MIN_V     = 16'(DELAY_MIN_MS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_GO      = 3'd2,
    S_DONE    = 3'd3,
    S_FOUL    = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          start_prev_q, react_prev_q;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   delay_q, delay_d;
  logic [13:0]   reaction_q, reaction_d;
  logic          result_valid_q, result_valid_d;
  logic          foul_q, foul_d;
  logic          timeout_q, timeout_d;

  logic          start_edge;
  logic          react_edge;
  logic          tick;
  logic          lfsr_fb;
  logic [15:0]   trial_delay;

  always_comb begin
    start_edge  = rt.start_sustain & ~start_prev_q;
    react_edge  = rt.react_sustain & ~react_prev_q;
    tick        = (presc_q == TICK_LAST);
    // Right-shifting Fibonacci form of taps 16,14,13,11.
    lfsr_fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d      = {lfsr_fb, lfsr_q[15:1]};
    trial_delay = (FIXED_V != 16'd0) ? FIXED_V : (MIN_V + {5'd0, lfsr_q[10:0]});
  end

  always_comb begin
    state_d        = state_q;
    presc_d        = presc_q;
    delay_d        = delay_q;
    reaction_d     = reaction_q;
    result_valid_d = 1'b0;
    foul_d         = foul_q;
    timeout_d      = timeout_q;

    if (state_q == S_WAIT || state_q == S_GO) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_FOUL, S_TIMEOUT: begin
        if (start_edge) begin
          state_d    = S_WAIT;
          presc_d    = '0;
          delay_d    = trial_delay;
          reaction_d = '0;
          foul_d     = 1'b0;
          timeout_d  = 1'b0;
        end
      end

      S_WAIT: begin
        // A react press beats a GO transition landing in the same cycle.
        if (react_edge) begin
          state_d        = S_FOUL;
          result_valid_d = 1'b1;
          foul_d         = 1'b1;
        end else if (tick) begin
          if (delay_q <= 16'd1) begin
            state_d    = S_GO;
            presc_d    = '0;
            delay_d    = '0;
            reaction_d = '0;
          end else begin
            delay_d = delay_q - 16'd1;
          end
        end
      end

      S_GO: begin
        if (react_edge) begin
          state_d        = S_DONE;
          result_valid_d = 1'b1;
        end else if (tick) begin
          if (reaction_q >= MAX_V - 14'd1) begin
            state_d        = S_TIMEOUT;
            reaction_d     = MAX_V;
            timeout_d      = 1'b1;
            result_valid_d = 1'b1;
          end else begin
            reaction_d = reaction_q + 14'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      start_prev_q   <= 1'b0;
      react_prev_q   <= 1'b0;
      lfsr_q         <= 16'hACE1;
      presc_q        <= '0;
      delay_q        <= '0;
      reaction_q     <= '0;
      result_valid_q <= 1'b0;
      foul_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_prev_q   <= rt.start_sustain;
      react_prev_q   <= rt.react_sustain;
      lfsr_q         <= lfsr_d;
      presc_q        <= presc_d;
      delay_q        <= delay_d;
      reaction_q     <= reaction_d;
      result_valid_q <= result_valid_d;
      foul_q         <= foul_d;
      timeout_q      <= timeout_d;
    end
  end

  assign rt.led_go       = (state_q == S_GO);
  assign rt.busy         = (state_q == S_WAIT) || (state_q == S_GO);
  assign rt.reaction_ms  = reaction_q;
  assign rt.result_valid = result_valid_q;
  assign rt.foul         = foul_q;
  assign rt.timeout      = timeout_q;
  assign rt.state_dbg    = state_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer: directed boundary trials plus randomized trials scored against an
// arithmetic timing model; a second instance exercises the random delay range.
module tb_reaction_timer;
  localparam int T      = 4;
  localparam int FIX_D  = 3;
  localparam int MAX    = 20;
  localparam int GO_OFS = 1 + T * FIX_D;
  localparam int TO_OFS = GO_OFS + T * MAX;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reaction_timer_if bus ();
  reaction_timer_if bus2 ();

  reaction_timer #(
    .TICKS_PER_MS(T), .DELAY_MIN_MS(1000), .FIXED_DELAY_MS(FIX_D), .MAX_MS(MAX)
  ) dut (
    .clock(clk), .reset(rst), .rt(bus)
  );

  reaction_timer #(
    .TICKS_PER_MS(T), .DELAY_MIN_MS(2), .FIXED_DELAY_MS(0), .MAX_MS(MAX)
  ) dut2 (
    .clock(clk), .reset(rst), .rt(bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // k: cycles from the start press to the react press (-1 = never); sr: start re-press offset (0 = none).
  task automatic run_trial(input int id, input int k, input int sr_in);
    bit   held, edge_ok, exp_foul, exp_to;
    int   exp_r, exp_go, exp_ms, sr;
    int   obs_r, obs_go, pulses;

    held    = bus.react_sustain;
    edge_ok = (k >= 2) || (k == 1 && !held);
    if (edge_ok && k < GO_OFS) begin
      exp_foul = 1'b1; exp_to = 1'b0; exp_ms = 0; exp_r = k + 1; exp_go = -1;
    end else if (edge_ok && (k - GO_OFS) < T * MAX) begin
      exp_foul = 1'b0; exp_to = 1'b0; exp_ms = (k - GO_OFS) / T; exp_r = k + 1; exp_go = GO_OFS;
    end else begin
      exp_foul = 1'b0; exp_to = 1'b1; exp_ms = MAX; exp_r = TO_OFS; exp_go = GO_OFS;
    end
    exp_q.push_back({exp_foul, exp_to, 14'(exp_ms)});
    sr = (sr_in >= 4 && sr_in < exp_r) ? sr_in : 0;

    obs_r = -1; obs_go = -1; pulses = 0;
    bus.start_sustain = 1'b1;
    if (k == 0) bus.react_sustain = 1'b1;
    for (int n = 1; n <= exp_r + 2; n++) begin
      step();
      if (n == 1) begin
        check_eq($sformatf("t%0d_busy_on", id), bus.busy, 1);
        check_eq($sformatf("t%0d_ms_clear", id), bus.reaction_ms, 0);
        check_eq($sformatf("t%0d_flags_clear", id), {bus.foul, bus.timeout}, 0);
      end
      if (bus.led_go && obs_go < 0) obs_go = n;
      if (bus.result_valid) begin
        pulses++;
        if (obs_r < 0) begin
          obs_r = n;
          check_eq($sformatf("t%0d_q_nonempty", id), exp_q.size() > 0, 1);
          if (exp_q.size() > 0)
            check_eq($sformatf("t%0d_result", id),
                     {16'd0, bus.foul, bus.timeout, bus.reaction_ms}, {16'd0, exp_q.pop_front()});
        end
      end
      if (n == exp_r) begin
        check_eq($sformatf("t%0d_idle_busy", id), bus.busy, 0);
        check_eq($sformatf("t%0d_idle_go", id), bus.led_go, 0);
      end
      if (n == exp_r + 2)
        check_eq($sformatf("t%0d_ms_hold", id), bus.reaction_ms, exp_ms);
      if (n == 1 && k != 1) bus.react_sustain = 1'b0;
      if (n == 2) bus.start_sustain = 1'b0;
      if (sr != 0 && n == sr) bus.start_sustain = 1'b1;
      if (sr != 0 && n == sr + 1) bus.start_sustain = 1'b0;
      if (n == k) bus.react_sustain = 1'b1;
    end
    check_eq($sformatf("t%0d_result_cycle", id), obs_r, exp_r);
    check_eq($sformatf("t%0d_go_cycle", id), obs_go, exp_go);
    check_eq($sformatf("t%0d_pulses", id), pulses, 1);
    if (obs_r < 0 && exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic measure_delay(input int id, output int d);
    int n;
    n = 0;
    bus2.start_sustain = 1'b1;
    while (!bus2.led_go && n < T * 2050 + 8) begin
      step();
      n++;
      if (n == 2) bus2.start_sustain = 1'b0;
    end
    check_eq($sformatf("d%0d_go_seen", id), bus2.led_go, 1);
    check_eq($sformatf("d%0d_ms_align", id), (n - 1) % T, 0);
    d = (n - 1) / T;
    check_eq($sformatf("d%0d_range", id), (d >= 2 && d <= 2049), 1);
    n = 0;
    while (!bus2.result_valid && n < T * MAX + 4) begin
      step();
      n++;
    end
    check_eq($sformatf("d%0d_timeout", id), {bus2.result_valid, bus2.timeout, bus2.reaction_ms},
             {1'b1, 1'b1, 14'(MAX)});
  endtask

  initial begin
    int d1, d2;
    bus.start_sustain  = 1'b0;
    bus.react_sustain  = 1'b0;
    bus2.start_sustain = 1'b0;
    bus2.react_sustain = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check_eq("rst_outputs", {bus.led_go, bus.busy, bus.result_valid, bus.foul, bus.timeout}, 0);
    check_eq("rst_ms", bus.reaction_ms, 0);
    rst = 1'b0;
    repeat (2) step();
    check_eq("idle_busy", bus.busy, 0);

    run_trial(1, GO_OFS + 21, 0);       // react 21 cycles after GO: 5 ms
    run_trial(2, 1, 0);                 // react still held: no edge, times out
    run_trial(3, GO_OFS + 27, 0);       // held react released then pressed
    run_trial(4, 6, 0);                 // early press in WAIT
    run_trial(5, -1, 0);                // no react at all
    run_trial(6, GO_OFS - 1, 0);        // press on the final WAIT tick
    run_trial(7, GO_OFS, 9);            // press on first GO cycle, start re-press ignored
    run_trial(8, TO_OFS - 1, 30);       // press on the 20th tick beats timeout
    run_trial(9, TO_OFS, 0);            // one cycle too late
    bus.react_sustain = 1'b0;
    step();
    run_trial(10, 0, 0);                // simultaneous start and react: start wins

    // Reset in the middle of GO.
    bus.react_sustain = 1'b0;
    step();
    bus.start_sustain = 1'b1;
    for (int n = 1; n <= GO_OFS + 6; n++) begin
      step();
      if (n == 2) bus.start_sustain = 1'b0;
    end
    check_eq("mid_go_led", bus.led_go, 1);
    check_eq("mid_go_ms", bus.reaction_ms, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_go_outputs", {bus.led_go, bus.busy, bus.result_valid, bus.foul, bus.timeout}, 0);
    check_eq("rst_go_ms", bus.reaction_ms, 0);
    step();
    rst = 1'b0;
    step();
    run_trial(11, GO_OFS + 9, 0);

    for (int i = 0; i < 20; i++) begin
      int k, sr;
      k  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 100));
      sr = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(4, 60));
      if ($urandom_range(0, 1) == 0) bus.react_sustain = 1'b0;
      repeat ($urandom_range(1, 5)) step();
      run_trial(100 + i, k, sr);
    end

    measure_delay(1, d1);
    repeat ($urandom_range(3, 40)) step();
    measure_delay(2, d2);
    check_eq("delay_differs", d1 != d2, 1);

    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
